mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Round-robin scheduler that shares one pipelined 8x8 `array_multiplier` among NUM_REQ requesters.
- Accepts operand pairs over per-requester valid/ready, launches at most one multiply per cycle, and tracks each launch with a requester tag through the multiplier's fixed latency.
- Returns each product to the requester that issued it.
- Sits between client blocks and the multiplier's A/B/i_valid/Z_reg/o_valid ports.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- WIDTH, 8: operand width; product is 2*WIDTH
- LATENCY, 2: cycles from multiplier i_valid to o_valid, >=1
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- hold  in  1  1 = issue no new grants (drain mode)
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_a  in  NUM_REQ x WIDTH  operand A per requester
- req_b  in  NUM_REQ x WIDTH  operand B per requester
- rsp_valid  out  NUM_REQ  one-hot result strobe, one cycle
- rsp_z  out  2*WIDTH  product, broadcast, valid with rsp_valid
- mul_a, mul_b  out  WIDTH  to multiplier A/B
- mul_i_valid  out  1  to multiplier i_valid
- mul_z  in  2*WIDTH  from multiplier Z_reg
- mul_o_valid  in  1  from multiplier o_valid
- busy  out  1  any operation launched but not yet returned
- err_orphan  out  1  sticky: mul_o_valid seen with no matching tag

## Operation
- Arbitration: round-robin pointer `ptr`. Grant = first index i at or after `ptr` (mod NUM_REQ) with req_valid[i]=1.
  - req_ready[grant]=1 combinationally; all other req_ready bits are 0.
  - No grant while hold=1.
  - After a grant, ptr <= grant+1 mod NUM_REQ. ptr is unchanged when there is no grant.
- Launch: on a grant, register mul_a/mul_b <= req_a/req_b[grant] and mul_i_valid <= 1. Otherwise mul_i_valid <= 0 and mul_a/mul_b hold their values.
- Tag pipe: a LATENCY-deep shift register of {valid, id[$clog2(NUM_REQ)-1:0]}.
  - Loaded together with mul_i_valid and advances every cycle.
  - The tail entry aligns with mul_o_valid.
- Return: when mul_o_valid=1 and the tail tag is valid, register rsp_valid <= onehot(tail id) and rsp_z <= mul_z.
  - When mul_o_valid=1 and the tail tag is invalid, set err_orphan=1. It clears only on reset. No rsp is produced.
  - When the tail tag is valid and mul_o_valid=0, also set err_orphan=1 and drop the tag.
- Responses have no backpressure. The requester must sink rsp_valid in the cycle it is asserted.
- busy = mul_i_valid OR any tag valid OR any rsp_valid.
- Products are unsigned, full 2*WIDTH. No truncation or saturation.
- Asserting hold mid-stream stops new grants only. In-flight results still return. busy falls once the pipe drains.
- Reset mid-operation:
  - All tags, rsp_valid, mul_i_valid and err_orphan go to 0. ptr=0.
  - In-flight products are discarded. The multiplier shares rst, so no orphan can follow.

## Timing
- Reset values: req_ready=0 while rst=0, rsp_valid=0, rsp_z=0, mul_a=mul_b=0, mul_i_valid=0, busy=0, err_orphan=0.
- Handshake: transfer when req_valid[i] & req_ready[i] at a rising edge.
  - The requester holds operands and valid until accepted.
  - A requester may drop valid without penalty.
- Latency from accept edge to rsp_valid: LATENCY+2 cycles. For LATENCY=2, accept at edge n gives rsp_valid high after edge n+4 (1 launch register + LATENCY + 1 return register).
- Throughput: one accept per cycle sustained. With all NUM_REQ requesting, each requester is granted once every NUM_REQ cycles.
- Results return in issue order, one per cycle maximum.

## Structure
- Package `mult_arb_pkg`:
  - `tag_t` struct {logic vld; logic [ID_W-1:0] id}
  - ID_W function of NUM_REQ
  - localparam PROD_W = 2*WIDTH
- Sub-module `rr_arbiter` (NUM_REQ): inputs req vector, ptr, en; outputs one-hot grant and grant index. Purely combinational. ptr register lives in the parent.
- Top `mult_share_arb` holds ptr, launch registers, tag pipe and return registers.
- The bench instantiates it with `array_multiplier`, wiring Z_reg->mul_z and o_valid->mul_o_valid.

## Test plan
- Single request: requester 0, A=255, B=255, LATENCY=2.
  - req_ready[0] for 1 cycle.
  - rsp_valid=4'b0001 with rsp_z=65025 exactly 4 cycles after accept. busy then falls.
- All four requesters valid continuously with A=i+1, B=3.
  - Grants in order 0,1,2,3,0,...
  - rsp_z sequence 3,6,9,12 on rsp_valid 0001,0010,0100,1000 in consecutive cycles.
- Fairness after skip: only requesters 1 and 3 valid, ptr=2.
  - Grant order 3,1,3,1.
  - Requester 3 with A=170, B=3 returns 510.
- Hold: assert hold with 2 operations in flight.
  - No req_ready while hold=1. Both results still return.
  - busy=0 within LATENCY+2 cycles. Release hold and the next grant follows ptr.
- Reset mid-flight: drop rst with 3 operations in flight.
  - All outputs are 0 immediately (async). No rsp_valid after release. err_orphan stays 0.
- Orphan: force mul_o_valid=1 with an empty tag pipe.
  - err_orphan=1 next cycle, sticky until rst. rsp_valid stays 0.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and helpers for the multiplier-sharing scheduler.
//   tag_t      : {vld, id} record that follows each launch through the multiplier
//   id_width() : width of a requester index for a given requester count
//   prod_width(): product width for a given operand width
package mult_arb_pkg;

  // Requester counts run 2..8, so three id bits always suffice inside a tag.
  localparam int MAX_REQ  = 8;
  localparam int TAG_ID_W = 3;

  localparam int WIDTH_DEF = 8;
  localparam int PROD_W    = 2 * WIDTH_DEF;

  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mult_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant selection.
//   req       : request vector, one bit per requester
//   ptr       : first index to consider (search wraps modulo NUM_REQ)
//   en        : 0 forces an empty grant
//   grant     : one-hot grant, or zero when nothing is granted
//   grant_idx : index of the granted requester (0 when grant is zero)
// The pointer register lives in the parent.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  int  idx;
  logic found;

  // Scan NUM_REQ slots starting at ptr; the first requesting slot wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr) + off) % NUM_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// mult_share_arb: shares one pipelined multiplier among NUM_REQ requesters.
//   clk, rst              : clock, asynchronous active-low reset
//   hold                  : 1 = grant nothing new; in-flight work still returns
//   req_valid/req_ready   : per-requester handshake; a transfer happens on a
//                           rising edge where both bits of a requester are 1.
//                           req_ready is combinational, one-hot or zero, and the
//                           requester keeps operands stable until accepted.
//   req_a, req_b          : flattened operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid, rsp_z      : one-cycle one-hot result strobe plus broadcast product;
//                           no backpressure, the requester must take it.
//   mul_a, mul_b, mul_i_valid : launch registers toward the multiplier
//   mul_z, mul_o_valid    : multiplier result
//   busy                  : something launched and not yet returned
//   err_orphan            : sticky; a result and its tag did not line up
module mult_share_arb
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     hold,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [2*WIDTH-1:0]       rsp_z,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  output logic                     mul_i_valid,
  input  logic [2*WIDTH-1:0]       mul_z,
  input  logic                     mul_o_valid,
  output logic                     busy,
  output logic                     err_orphan
);

  localparam int ID_W  = id_width(NUM_REQ);
  localparam int PW    = prod_width(WIDTH);
  // The multiplier captures its inputs on the edge after launch and raises
  // o_valid LATENCY edges after that capture, so the tag pipe mirrors that
  // capture stage plus LATENCY stages.
  localparam int DEPTH = LATENCY + 1;

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    launch_id;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               arb_en;

  tag_t               tag_q [DEPTH];
  tag_t               tail;
  logic [NUM_REQ-1:0] tail_onehot;
  logic               tags_busy;

  // No grant while in reset (req_ready must read 0) or while holding.
  assign arb_en = rst & ~hold;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign grant_any = |grant;

  always_comb begin
    ptr_nxt = grant_idx + 1'b1;
    if (int'(grant_idx) == NUM_REQ - 1) ptr_nxt = '0;
  end

  assign tail = tag_q[DEPTH-1];

  always_comb begin
    tail_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(tail.id) == i) tail_onehot[i] = 1'b1;
    end
  end

  always_comb begin
    tags_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) tags_busy = tags_busy | tag_q[k].vld;
  end

  assign busy = mul_i_valid | tags_busy | (|rsp_valid);

  // Launch: pointer, operand registers and the id that goes with them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_i_valid <= 1'b0;
      launch_id   <= '0;
    end else if (grant_any) begin
      ptr         <= ptr_nxt;
      mul_a       <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
      mul_b       <= req_b[int'(grant_idx)*WIDTH +: WIDTH];
      mul_i_valid <= 1'b1;
      launch_id   <= grant_idx;
    end else begin
      mul_i_valid <= 1'b0;
    end
  end

  // Tag pipe: shifts every cycle; an unmatched tail tag simply falls off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) tag_q[k] <= '0;
    end else begin
      tag_q[0] <= '{vld: mul_i_valid, id: TAG_ID_W'(launch_id)};
      for (int k = 1; k < DEPTH; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  // Return: route the product to the tail tag's owner, flag any mismatch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid  <= '0;
      rsp_z      <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (mul_o_valid && tail.vld) begin
        rsp_valid <= tail_onehot;
        rsp_z     <= mul_z[PW-1:0];
      end
      if (mul_o_valid != tail.vld) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// tb_mult_share_arb: self-checking bench for mult_share_arb with a behavioural
// pipelined multiplier (input capture + LATENCY stages).
module tb_mult_share_arb;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int LATENCY = 2;
  localparam int PW      = 2 * WIDTH;
  localparam int SW      = 32 + NUM_REQ + PW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic                     hold;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [PW-1:0]            rsp_z;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic                     mul_i_valid;
  logic [PW-1:0]            mul_z;
  logic                     mul_o_valid;
  logic                     busy;
  logic                     err_orphan;

  mult_share_arb #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_z       (rsp_z),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_i_valid (mul_i_valid),
    .mul_z       (mul_z),
    .mul_o_valid (mul_o_valid),
    .busy        (busy),
    .err_orphan  (err_orphan)
  );

  // ---------------- multiplier model ----------------
  logic          mp_v [LATENCY+1];
  logic [PW-1:0] mp_z [LATENCY+1];
  logic          force_ov;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k <= LATENCY; k++) begin
        mp_v[k] <= 1'b0;
        mp_z[k] <= '0;
      end
    end else begin
      mp_v[0] <= mul_i_valid;
      mp_z[0] <= PW'(mul_a) * PW'(mul_b);
      for (int k = 1; k <= LATENCY; k++) begin
        mp_v[k] <= mp_v[k-1];
        mp_z[k] <= mp_z[k-1];
      end
    end
  end

  assign mul_o_valid = mp_v[LATENCY] | force_ov;
  assign mul_z       = mp_z[LATENCY];

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard entry: {expected sample cycle, one-hot owner, product}
  logic [SW-1:0]      exp_q[$];
  logic [NUM_REQ-1:0] last_accept;
  logic [NUM_REQ-1:0] mon_acc;
  logic [PW-1:0]      mon_prod;
  logic [SW-1:0]      mon_e;

  // Monitor on the falling edge: inputs are driven 2 time units after the
  // rising edge, so everything here is stable.
  always @(negedge clk) begin
    last_accept = '0;
    if (rst) begin
      mon_acc     = req_valid & req_ready;
      last_accept = mon_acc;
      check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
      if (mon_acc != '0) begin
        mon_prod = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (mon_acc[i]) mon_prod = PW'(req_a[i*WIDTH +: WIDTH]) * PW'(req_b[i*WIDTH +: WIDTH]);
        end
        // accept edge is the next one; result appears LATENCY+2 edges later
        exp_q.push_back({32'(cyc + 1 + LATENCY + 2), mon_acc, mon_prod});
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual=%0b required=none (t=%0t)", rsp_valid, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_cycle", 64'(cyc), 64'(mon_e[SW-1 -: 32]));
          check("rsp_owner", 64'(rsp_valid), 64'(mon_e[PW +: NUM_REQ]));
          check("rsp_z", 64'(rsp_z), 64'(mon_e[PW-1:0]));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [NUM_REQ-1:0]       rv;
    logic                     hold;
    logic [NUM_REQ*WIDTH-1:0] a;
    logic [NUM_REQ*WIDTH-1:0] b;
    logic [NUM_REQ-1:0]       exp_ready;
  } vec_t;

  vec_t vecs[12];

  task automatic apply_reset();
    rst       = 1'b0;
    exp_q.delete();
    req_valid = '0;
    hold      = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  int ready_cnt;
  int rsp_cnt;
  int after_rsp;
  int drained;
  int drain_at;
  int rsp_seen;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // all-valid rotation, A=i+1, B=3
    for (int r = 0; r < 6; r++) begin
      vecs[r].rv   = 4'b1111;
      vecs[r].hold = 1'b0;
      vecs[r].a    = {8'd4, 8'd3, 8'd2, 8'd1};
      vecs[r].b    = {8'd3, 8'd3, 8'd3, 8'd3};
    end
    vecs[0].exp_ready = 4'b0001;
    vecs[1].exp_ready = 4'b0010;
    vecs[2].exp_ready = 4'b0100;
    vecs[3].exp_ready = 4'b1000;
    vecs[4].exp_ready = 4'b0001;
    vecs[5].exp_ready = 4'b0010;
    // skip fairness from ptr=2 with only 1 and 3 valid; requester 3 A=170 B=3
    for (int r = 6; r < 12; r++) begin
      vecs[r].rv   = 4'b1010;
      vecs[r].hold = (r >= 10);
      vecs[r].a    = {8'd170, 8'd9, 8'd7, 8'd1};
      vecs[r].b    = {8'd3, 8'd3, 8'd11, 8'd3};
    end
    vecs[6].exp_ready  = 4'b1000;
    vecs[7].exp_ready  = 4'b0010;
    vecs[8].exp_ready  = 4'b1000;
    vecs[9].exp_ready  = 4'b0010;
    vecs[10].exp_ready = 4'b0000;
    vecs[11].exp_ready = 4'b0000;

    // ---- reset values (req_valid high to show req_ready is gated) ----
    rst = 1'b0; hold = 1'b0; force_ov = 1'b0;
    req_valid = '1; req_a = '0; req_b = '0;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_z", 64'(rsp_z), 64'd0);
    check("rst_mul_a", 64'(mul_a), 64'd0);
    check("rst_mul_b", 64'(mul_b), 64'd0);
    check("rst_mul_i_valid", 64'(mul_i_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_orphan", 64'(err_orphan), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    req_valid = '0;
    rst = 1'b1;

    // ---- single request: 255*255 on requester 0 ----
    req_a[7:0] = 8'd255;
    req_b[7:0] = 8'd255;
    req_valid  = 4'b0001;
    ready_cnt = 0; rsp_cnt = 0; after_rsp = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_ready[0]) ready_cnt++;
      if (after_rsp == 1) begin
        check("single_busy_fall", 64'(busy), 64'd0);
        after_rsp = 2;
      end
      if (rsp_valid != '0) begin
        rsp_cnt++;
        check("single_rsp_valid", 64'(rsp_valid), 64'b0001);
        check("single_rsp_z", 64'(rsp_z), 64'd65025);
        check("single_busy_at_rsp", 64'(busy), 64'd1);
        after_rsp = 1;
      end
      @(posedge clk);
      #2;
      if (last_accept[0]) req_valid[0] = 1'b0;
    end
    check("single_ready_cycles", 64'(ready_cnt), 64'd1);
    check("single_rsp_count", 64'(rsp_cnt), 64'd1);
    check("single_busy_seen_fall", 64'(after_rsp), 64'd2);

    // ---- table: rotation, skip fairness, hold ----
    apply_reset();
    for (int r = 0; r < 12; r++) begin
      req_valid = vecs[r].rv;
      hold      = vecs[r].hold;
      req_a     = vecs[r].a;
      req_b     = vecs[r].b;
      @(negedge clk);
      check($sformatf("vec%0d_ready", r), 64'(req_ready), 64'(vecs[r].exp_ready));
      @(posedge clk);
      #2;
    end

    // ---- hold continues: two results drain, no grants ----
    drained = 0; drain_at = -1;
    for (int c = 0; c < 8 && drained == 0; c++) begin
      @(negedge clk);
      check("hold_no_ready", 64'(req_ready), 64'd0);
      if (!busy) begin
        drained  = 1;
        drain_at = c;
      end
      @(posedge clk);
      #2;
    end
    check("hold_drained", 64'(drained), 64'd1);
    check("hold_drain_time", 64'(drain_at >= 0 && drain_at <= LATENCY + 2), 64'd1);
    hold = 1'b0;
    @(negedge clk);
    check("hold_release_grant", 64'(req_ready), 64'b1000);
    @(posedge clk);
    #2;
    req_valid = '0;
    repeat (8) @(posedge clk);
    #2;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_busy", 64'(busy), 64'd0);

    // ---- reset with three operations in flight ----
    req_a = {8'd4, 8'd3, 8'd2, 8'd1};
    req_b = {8'd5, 8'd5, 8'd5, 8'd5};
    req_valid = '1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_rsp_z", 64'(rsp_z), 64'd0);
    check("midrst_mul_i_valid", 64'(mul_i_valid), 64'd0);
    check("midrst_mul_a", 64'(mul_a), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_err", 64'(err_orphan), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    rsp_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid != '0) rsp_seen++;
    end
    check("midrst_no_rsp", 64'(rsp_seen), 64'd0);
    check("midrst_err_after", 64'(err_orphan), 64'd0);
    check("midrst_busy_after", 64'(busy), 64'd0);

    // ---- orphan: o_valid with an empty tag pipe ----
    @(posedge clk);
    #2;
    force_ov = 1'b1;
    @(posedge clk);
    #2;
    force_ov = 1'b0;
    @(negedge clk);
    check("orphan_set", 64'(err_orphan), 64'd1);
    check("orphan_no_rsp", 64'(rsp_valid), 64'd0);
    repeat (3) @(negedge clk);
    check("orphan_sticky", 64'(err_orphan), 64'd1);
    check("orphan_no_rsp_later", 64'(rsp_valid), 64'd0);
    rst = 1'b0;
    #1;
    check("orphan_cleared_by_rst", 64'(err_orphan), 64'd0);
    #20;
    rst = 1'b1;
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
